// File: rtl/ones_stream_if.sv
// Request handshake and framed serial stream between the ones-stream generator
// and whatever consumes it (ones counter, scoreboard).
interface ones_stream_if;
    logic       req_valid;
    logic       req_ready;
    logic [0:3] req_count;
    logic       req_mode;
    logic       data;
    logic       frame_valid;
    logic       frame_last;
    logic [0:3] exp_count;
    logic       sat;
    logic       done;

    modport master (
        input  req_valid, req_count, req_mode,
        output req_ready, data, frame_valid, frame_last, exp_count, sat, done
    );

    modport slave (
        output req_valid, req_count, req_mode,
        input  req_ready, data, frame_valid, frame_last, exp_count, sat, done
    );
endinterface

// File: rtl/ones_stream_gen.sv
// Framed serial stimulus generator: accepts a ones-count request and emits a
// FRAME_LEN-bit frame holding exactly that many ones, followed by a forced-zero gap.
module ones_stream_gen #(
    parameter int FRAME_LEN  = 15,
    parameter int GAP_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    ones_stream_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [4:0] FL       = 5'(FRAME_LEN);
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    logic [1:0] r_state;
    logic [3:0] r_idx;
    logic [3:0] r_gap;
    logic [3:0] r_n;
    logic       r_mode;
    logic       r_data;
    logic       r_fv;
    logic       r_fl;
    logic       r_done;
    logic [3:0] r_exp;
    logic       r_sat;

    logic [3:0] w_req_count;
    logic       w_sat;
    logic [3:0] w_clamped;
    logic       w_ready;
    logic       w_accept;
    logic [3:0] w_idx_next;

    // Ones sit at the front of the frame (mode 0) or at its tail (mode 1).
    function automatic logic bit_at(input logic [3:0] idx, input logic [3:0] n,
                                    input logic mode);
        logic [4:0] thr;
        thr = FL - {1'b0, n};
        return mode ? ({1'b0, idx} >= thr) : (idx < n);
    endfunction

    assign w_req_count = bus.req_count;
    assign w_sat       = ({1'b0, w_req_count} > FL);
    assign w_clamped   = w_sat ? FL[3:0] : w_req_count;
    assign w_ready     = (r_state == S_IDLE);
    assign w_accept    = bus.req_valid && w_ready;
    assign w_idx_next  = r_idx + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_gap   <= '0;
            r_n     <= '0;
            r_mode  <= 1'b0;
            r_data  <= 1'b0;
            r_fv    <= 1'b0;
            r_fl    <= 1'b0;
            r_done  <= 1'b0;
            r_exp   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_n     <= w_clamped;
                        r_mode  <= bus.req_mode;
                        r_exp   <= w_clamped;
                        r_sat   <= w_sat;
                        r_idx   <= '0;
                        r_data  <= bit_at(4'd0, w_clamped, bus.req_mode);
                        r_fv    <= 1'b1;
                        r_fl    <= (LAST_IDX == 4'd0);
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    // r_idx names the bit currently on the output register.
                    if (r_idx == LAST_IDX) begin
                        r_data  <= 1'b0;
                        r_fv    <= 1'b0;
                        r_fl    <= 1'b0;
                        r_done  <= 1'b1;
                        r_gap   <= '0;
                        r_state <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                    end else begin
                        r_idx  <= w_idx_next;
                        r_data <= bit_at(w_idx_next, r_n, r_mode);
                        r_fl   <= (w_idx_next == LAST_IDX);
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.data        = r_data;
    assign bus.frame_valid = r_fv;
    assign bus.frame_last  = r_fl;
    assign bus.exp_count   = r_exp;
    assign bus.sat         = r_sat;
    assign bus.done        = r_done;
endmodule

// File: tb/tb_ones_stream_gen.sv
// Directed bench for ones_stream_gen: three instances cover the default
// geometry, a short frame for clamping, and a zero-gap configuration.
module tb_ones_stream_gen;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   sel;

    logic       rv [3];
    logic [0:3] rc [3];
    logic       rm [3];

    ones_stream_if if0 ();
    ones_stream_if if1 ();
    ones_stream_if if2 ();

    assign if0.req_valid = rv[0];
    assign if0.req_count = rc[0];
    assign if0.req_mode  = rm[0];
    assign if1.req_valid = rv[1];
    assign if1.req_count = rc[1];
    assign if1.req_mode  = rm[1];
    assign if2.req_valid = rv[2];
    assign if2.req_count = rc[2];
    assign if2.req_mode  = rm[2];

    ones_stream_gen #(.FRAME_LEN(15), .GAP_CYCLES(2)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    ones_stream_gen #(.FRAME_LEN(8),  .GAP_CYCLES(2)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    ones_stream_gen #(.FRAME_LEN(15), .GAP_CYCLES(0)) dut2 (.clk(clk), .reset(reset), .bus(if2));

    logic       s_ready, s_data, s_fv, s_fl, s_sat, s_done;
    logic [3:0] s_exp;

    always_comb begin
        s_ready = 1'b0; s_data = 1'b0; s_fv = 1'b0; s_fl = 1'b0;
        s_sat = 1'b0; s_done = 1'b0; s_exp = 4'd0;
        case (sel)
            0: begin
                s_ready = if0.req_ready; s_data = if0.data; s_fv = if0.frame_valid;
                s_fl = if0.frame_last; s_sat = if0.sat; s_done = if0.done; s_exp = if0.exp_count;
            end
            1: begin
                s_ready = if1.req_ready; s_data = if1.data; s_fv = if1.frame_valid;
                s_fl = if1.frame_last; s_sat = if1.sat; s_done = if1.done; s_exp = if1.exp_count;
            end
            default: begin
                s_ready = if2.req_ready; s_data = if2.data; s_fv = if2.frame_valid;
                s_fl = if2.frame_last; s_sat = if2.sat; s_done = if2.done; s_exp = if2.exp_count;
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits for ready, issues one request, and records one full frame plus the cycle after it.
    task automatic run_frame(input int w, input int flen, input logic [3:0] cnt, input logic mode,
                             output logic [14:0] bits, output logic [14:0] fvs,
                             output logic [14:0] lasts, output logic done_nxt,
                             output logic ready_nxt);
        int waited;
        sel = w;
        bits = '0; fvs = '0; lasts = '0;
        @(negedge clk);
        waited = 0;
        while (!s_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout dut%0d: req_ready stayed 0 for %0d cycles", w, waited);
        end
        rv[w] = 1'b1; rc[w] = cnt; rm[w] = mode;
        @(negedge clk);
        rv[w] = 1'b0; rc[w] = ~cnt;
        for (int i = 0; i < flen; i++) begin
            bits[i] = s_data; fvs[i] = s_fv; lasts[i] = s_fl;
            @(negedge clk);
        end
        done_nxt = s_done;
        ready_nxt = s_ready;
        $display("dut%0d req=%0d mode=%0d -> bits=%h exp=%0d sat=%0d done=%0d",
                 w, cnt, mode, bits, s_exp, s_sat, done_nxt);
    endtask

    task automatic test_reset();
        sel = 0;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", s_ready); end
        checks++; if (s_exp !== 4'd0) begin errors++; $display("FAIL reset_exp got %0d want 0", s_exp); end
        checks++; if (s_sat !== 1'b0 || s_fv !== 1'b0 || s_done !== 1'b0 || s_data !== 1'b0) begin
            errors++; $display("FAIL reset_outs got sat=%b fv=%b done=%b data=%b want 0", s_sat, s_fv, s_done, s_data);
        end
        rv[0] = 1'b1; rc[0] = 4'd9; rm[0] = 1'b0;
        @(negedge clk);
        rv[0] = 1'b0;
        checks++; if (s_data !== 1'b1 || s_exp !== 4'd9) begin
            errors++; $display("FAIL pre_reset_emit got data=%b exp=%0d want 1/9", s_data, s_exp);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (s_data !== 1'b0 || s_fv !== 1'b0 || s_exp !== 4'd0 || s_ready !== 1'b1 || s_done !== 1'b0) begin
                errors++;
                $display("FAIL mid_frame_reset cyc%0d got data=%b fv=%b exp=%0d ready=%b done=%b want 0/0/0/1/0",
                         k, s_data, s_fv, s_exp, s_ready, s_done);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1 || s_done !== 1'b0) begin
            errors++; $display("FAIL post_reset got ready=%b done=%b want 1/0", s_ready, s_done);
        end
        $display("reset mid-EMIT checked");
    endtask

    task automatic test_leading();
        logic [14:0] b, f, l; logic d, r;
        run_frame(0, 15, 4'd5, 1'b0, b, f, l, d, r);
        checks++; if (b !== 15'h001F) begin errors++; $display("FAIL lead_bits got %h want 001f", b); end
        checks++; if (f !== 15'h7FFF) begin errors++; $display("FAIL lead_fv got %h want 7fff", f); end
        checks++; if (l !== 15'h4000) begin errors++; $display("FAIL lead_last got %h want 4000", l); end
        checks++; if (d !== 1'b1 || r !== 1'b0) begin errors++; $display("FAIL lead_done got done=%b ready=%b want 1/0", d, r); end
        checks++; if (s_exp !== 4'd5 || s_sat !== 1'b0) begin errors++; $display("FAIL lead_exp got %0d sat=%b want 5/0", s_exp, s_sat); end
    endtask

    task automatic test_trailing();
        logic [14:0] b, f, l; logic d, r;
        run_frame(0, 15, 4'd3, 1'b1, b, f, l, d, r);
        checks++; if (b !== 15'h7000) begin errors++; $display("FAIL trail_bits got %h want 7000", b); end
        checks++; if ($countones(b) !== 3) begin errors++; $display("FAIL trail_ones got %0d want 3", $countones(b)); end
        checks++; if (s_exp !== 4'd3 || d !== 1'b1) begin errors++; $display("FAIL trail_exp got %0d done=%b want 3/1", s_exp, d); end
    endtask

    task automatic test_extremes();
        logic [14:0] b, f, l; logic d, r;
        run_frame(0, 15, 4'd0, 1'b0, b, f, l, d, r);
        checks++; if (b !== 15'h0000 || f !== 15'h7FFF) begin errors++; $display("FAIL zero_frame got bits=%h fv=%h want 0000/7fff", b, f); end
        checks++; if (d !== 1'b1 || l !== 15'h4000 || s_exp !== 4'd0) begin
            errors++; $display("FAIL zero_done got done=%b last=%h exp=%0d want 1/4000/0", d, l, s_exp);
        end
        run_frame(0, 15, 4'd15, 1'b1, b, f, l, d, r);
        checks++; if (b !== 15'h7FFF) begin errors++; $display("FAIL full_frame got %h want 7fff", b); end
        checks++; if (s_exp !== 4'd15 || s_sat !== 1'b0) begin errors++; $display("FAIL full_exp got %0d sat=%b want 15/0", s_exp, s_sat); end
    endtask

    task automatic test_clamp();
        logic [14:0] b, f, l; logic d, r;
        run_frame(1, 8, 4'd12, 1'b0, b, f, l, d, r);
        checks++; if (b !== 15'h00FF || f !== 15'h00FF) begin errors++; $display("FAIL clamp_bits got %h fv=%h want 00ff/00ff", b, f); end
        checks++; if (s_exp !== 4'd8 || s_sat !== 1'b1) begin errors++; $display("FAIL clamp_exp got %0d sat=%b want 8/1", s_exp, s_sat); end
        checks++; if (l !== 15'h0080 || d !== 1'b1) begin errors++; $display("FAIL clamp_last got %h done=%b want 0080/1", l, d); end
        run_frame(1, 8, 4'd3, 1'b1, b, f, l, d, r);
        checks++; if (b !== 15'h00E0) begin errors++; $display("FAIL short_trail got %h want 00e0", b); end
        checks++; if (s_exp !== 4'd3 || s_sat !== 1'b0) begin errors++; $display("FAIL sat_clear got %0d sat=%b want 3/0", s_exp, s_sat); end
    endtask

    task automatic test_no_gap();
        logic [14:0] b, f, l; logic d, r;
        run_frame(2, 15, 4'd4, 1'b1, b, f, l, d, r);
        checks++; if (b !== 15'h7800) begin errors++; $display("FAIL nogap_bits got %h want 7800", b); end
        checks++; if (d !== 1'b1 || r !== 1'b1) begin errors++; $display("FAIL nogap_done got done=%b ready=%b want 1/1", d, r); end
    endtask

    task automatic test_back_to_back(input int w, input int exp_spacing, input int exp_gaps);
        int n, acc0, acc1, gaps, stray, c;
        logic [3:0] first_exp;
        sel = w; n = 0; acc0 = 0; acc1 = 0; gaps = 0; stray = 0; first_exp = 4'd0;
        @(negedge clk);
        rv[w] = 1'b1; rc[w] = 4'd7; rm[w] = 1'b0;
        for (c = 0; c < 100 && n < 2; c++) begin
            if (s_ready && rv[w]) begin
                if (n == 0) acc0 = c; else acc1 = c;
                n++;
            end else if (n == 1 && !s_fv) begin
                gaps++;
                if (s_data || s_ready) stray++;
            end
            @(negedge clk);
            if (n == 1 && c == acc0) begin
                first_exp = s_exp;
                rc[w] = 4'd2;
            end
        end
        rv[w] = 1'b0;
        checks++; if (n !== 2) begin errors++; $display("FAIL b2b_timeout dut%0d got %0d acceptances want 2", w, n); end
        checks++; if (acc1 - acc0 !== exp_spacing) begin
            errors++; $display("FAIL b2b_spacing dut%0d got %0d want %0d", w, acc1 - acc0, exp_spacing);
        end
        checks++; if (gaps !== exp_gaps || stray !== 0) begin
            errors++; $display("FAIL b2b_gap dut%0d got gaps=%0d stray=%0d want %0d/0", w, gaps, stray, exp_gaps);
        end
        checks++; if (first_exp !== 4'd7 || s_exp !== 4'd2) begin
            errors++; $display("FAIL b2b_exp dut%0d got %0d,%0d want 7,2", w, first_exp, s_exp);
        end
        $display("dut%0d back-to-back spacing=%0d gaps=%0d", w, acc1 - acc0, gaps);
    endtask

    initial begin
        checks = 0; errors = 0; sel = 0;
        for (int k = 0; k < 3; k++) begin
            rv[k] = 1'b0; rc[k] = 4'd0; rm[k] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_leading();
        test_trailing();
        test_extremes();
        test_clamp();
        test_no_gap();
        test_back_to_back(0, 18, 2);
        test_back_to_back(2, 16, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
